simon_round_ctrl: RTL and testbench
===================================

Name: simon_round_ctrl

Overview:
- Round sequencer for the Simon Says game; drives the colour segment array.
- Each round it appends one random colour to the array, then plays the stored sequence on the LEDs, oldest colour first, with fixed on and off times.
- It then checks the player's button presses against the stored sequence.
- Reports win or fail to the top-level FSM and owns the array's clear and load controls.

Parameters:
- MAX_LEN, 32, maximum sequence length; reaching it ends the game with a win (legal range 1..32).
- ON_CYCLES, 25000000, clk cycles each colour is lit during playback.
- OFF_CYCLES, 12500000, clk cycles of dark gap after each colour.
- TIMEOUT_CYCLES, 250000000, clk cycles allowed between player presses before fail.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  one-cycle pulse, begins a new game (honoured only in IDLE)
- rand_colour  in  2  colour to append this round, sampled in CLEAR and after each passed round
- segment  in  66  stored colours; entry i at bits [2i+1:2i]; entry 0 is newest
- btn_valid  in  1  one-cycle pulse, player pressed a button
- btn_colour  in  2  colour of the press, valid with btn_valid
- seg_clear  out  1  clears the array (top ORs it into the array reset)
- load_colour  out  1  array shift-in strobe
- new_colour  out  2  colour shifted in while load_colour=1
- led_en  out  1  playback LED enable
- led_colour  out  2  playback colour
- awaiting_input  out  1  high while player input is accepted
- round_len  out  6  current sequence length, 0..MAX_LEN
- busy  out  1  high in every state except IDLE
- win  out  1  one-cycle pulse, game won
- fail  out  1  one-cycle pulse, game lost

Behaviour:
- Reset: state IDLE; all outputs 0; round_len=0; timer and index cleared. Reset mid-game aborts immediately, with no win or fail pulse.
- All outputs are registered or Moore-decoded from state; no combinational path from inputs to outputs.
- IDLE: start=1 -> CLEAR. btn_valid is ignored.
- CLEAR, 1 cycle:
  - seg_clear=1; round_len<=0; new_colour<=rand_colour.
  - Next state ADD.
- ADD, 1 cycle:
  - load_colour=1 and new_colour held.
  - round_len<=round_len+1; idx<=round_len, i.e. the new length minus 1 (oldest entry).
  - Array updates at the end of this cycle.
  - Next state SHOW_ON.
- SHOW_ON:
  - led_en=1; led_colour=segment[idx], registered on entry.
  - Stays exactly ON_CYCLES cycles, then -> SHOW_OFF.
- SHOW_OFF:
  - led_en=0 for exactly OFF_CYCLES cycles.
  - If idx!=0: idx<=idx-1 and -> SHOW_ON.
  - Else: idx<=round_len-1, timer cleared, -> WAIT_IN.
- WAIT_IN:
  - awaiting_input=1.
  - On btn_valid, compare btn_colour with segment[idx].
  - Mismatch -> FAIL.
  - Match, idx!=0 -> idx<=idx-1, timer cleared, stay.
  - Match, idx==0, round_len<MAX_LEN -> new_colour<=rand_colour, -> ADD (next round).
  - Match, idx==0, round_len==MAX_LEN -> WIN.
  - No press for TIMEOUT_CYCLES consecutive cycles -> FAIL.
  - If the timeout and btn_valid occur in the same cycle, the press wins.
- FAIL / WIN, 1 cycle each: the matching pulse is 1; round_len is held for display; -> IDLE.
- start outside IDLE is ignored; start in the same cycle as FAIL/WIN is ignored.
- btn_valid outside WAIT_IN is dropped, with no effect on state.
- Timer: one down-counter, width clog2 of the largest parameter; reloaded on every state entry.
- Playback order is oldest to newest (index round_len-1 down to 0); input order is identical.

Test Plan:
Parameters for the bench: MAX_LEN=3, ON_CYCLES=4, OFF_CYCLES=2, TIMEOUT_CYCLES=20.
1. Reset, then start with rand_colour=2:
   - seg_clear high exactly 1 cycle, then load_colour high 1 cycle with new_colour=2.
   - round_len=1; led_en high 4 cycles with led_colour=2, low 2 cycles.
   - awaiting_input=1.
2. Round 1 press btn_colour=2, round 2 rand=1:
   - Playback is 2 then 1 (4 on / 2 off each).
   - Pressing 2 then 1 advances to round 3 with round_len=3.
3. Full game of 3 correct rounds -> win pulses once, 1 cycle after the last press; state IDLE; busy=0; round_len=3.
4. Round 2, first press wrong (btn_colour=3, expected 2) -> fail pulses next cycle; later presses are ignored; start restarts with round_len=1.
5. No press for 20 cycles in WAIT_IN -> fail pulse. A press on cycle 20 is taken as input, not a timeout.
6. Reset asserted mid-SHOW_ON -> next cycle all outputs 0, no fail/win; start pulses and btn_valid during playback are ignored, with no change to idx or state.

Source files
------------

// File: rtl/simon_round_ctrl.sv
// Simon Says round sequencer: grows the colour sequence one entry per round,
// plays it back on the LEDs oldest first, then checks the player's presses.
module simon_round_ctrl #(
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned ON_CYCLES      = 25000000,
  parameter int unsigned OFF_CYCLES     = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  rand_colour,
  input  logic [65:0] segment,
  input  logic        btn_valid,
  input  logic [1:0]  btn_colour,
  output logic        seg_clear,
  output logic        load_colour,
  output logic [1:0]  new_colour,
  output logic        led_en,
  output logic [1:0]  led_colour,
  output logic        awaiting_input,
  output logic [5:0]  round_len,
  output logic        busy,
  output logic        win,
  output logic        fail
);

  localparam int unsigned MAX_AB = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned MAX_P0 = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned MAX_P  = (MAX_P0 > MAX_LEN) ? MAX_P0 : MAX_LEN;
  localparam int unsigned TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    LEN_MAX = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_FAIL, S_WIN
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [4:0]    idx;

  function automatic logic [1:0] seg_at(input logic [4:0] i);
    return segment[{1'b0, i, 1'b0} +: 2];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      idx            <= '0;
      seg_clear      <= 1'b0;
      load_colour    <= 1'b0;
      new_colour     <= '0;
      led_en         <= 1'b0;
      led_colour     <= '0;
      awaiting_input <= 1'b0;
      round_len      <= '0;
      busy           <= 1'b0;
      win            <= 1'b0;
      fail           <= 1'b0;
    end else begin
      seg_clear   <= 1'b0;
      load_colour <= 1'b0;
      win         <= 1'b0;
      fail        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            seg_clear <= 1'b1;
            busy      <= 1'b1;
            timer     <= '0;
          end
        end
        S_CLEAR: begin
          round_len   <= '0;
          new_colour  <= rand_colour;
          load_colour <= 1'b1;
          state       <= S_ADD;
          timer       <= '0;
        end
        S_ADD: begin
          round_len <= round_len + 6'd1;
          idx       <= round_len[4:0];
          // The array shifts at this edge, so the oldest entry after the shift
          // is today's entry round_len-1, or the colour being loaded if empty.
          led_colour <= (round_len == '0) ? new_colour : seg_at(5'(round_len - 6'd1));
          led_en     <= 1'b1;
          timer      <= ON_LD;
          state      <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (timer == '0) begin
            led_en <= 1'b0;
            timer  <= OFF_LD;
            state  <= S_SHOW_OFF;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_SHOW_OFF: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (idx != '0) begin
            idx        <= idx - 5'd1;
            led_colour <= seg_at(idx - 5'd1);
            led_en     <= 1'b1;
            timer      <= ON_LD;
            state      <= S_SHOW_ON;
          end else begin
            idx            <= 5'(round_len - 6'd1);
            timer          <= TO_LD;
            awaiting_input <= 1'b1;
            state          <= S_WAIT_IN;
          end
        end
        S_WAIT_IN: begin
          if (btn_valid) begin
            if (btn_colour != seg_at(idx)) begin
              fail           <= 1'b1;
              awaiting_input <= 1'b0;
              timer          <= '0;
              state          <= S_FAIL;
            end else if (idx != '0) begin
              idx   <= idx - 5'd1;
              timer <= TO_LD;
            end else if (round_len < LEN_MAX) begin
              new_colour     <= rand_colour;
              load_colour    <= 1'b1;
              awaiting_input <= 1'b0;
              timer          <= '0;
              state          <= S_ADD;
            end else begin
              win            <= 1'b1;
              awaiting_input <= 1'b0;
              timer          <= '0;
              state          <= S_WIN;
            end
          end else if (timer == '0) begin
            fail           <= 1'b1;
            awaiting_input <= 1'b0;
            state          <= S_FAIL;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_FAIL, S_WIN: begin
          busy  <= 1'b0;
          timer <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl with a colour-array model and a
// scoreboard of colours expected on the LEDs and at the player input.
module tb_simon_round_ctrl;

  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 2;
  localparam int unsigned TO  = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  rand_colour = '0;
  logic [65:0] segment = '0;
  logic        btn_valid = 1'b0;
  logic [1:0]  btn_colour = '0;
  logic        seg_clear, load_colour, led_en, awaiting_input, busy, win, fail;
  logic [1:0]  new_colour, led_colour;
  logic [5:0]  round_len;

  int tests = 0;
  int failed = 0;
  logic [1:0] colours[$];

  simon_round_ctrl #(
    .MAX_LEN(3), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rand_colour(rand_colour),
    .segment(segment), .btn_valid(btn_valid), .btn_colour(btn_colour),
    .seg_clear(seg_clear), .load_colour(load_colour), .new_colour(new_colour),
    .led_en(led_en), .led_colour(led_colour), .awaiting_input(awaiting_input),
    .round_len(round_len), .busy(busy), .win(win), .fail(fail)
  );

  always #5 clk = ~clk;

  // Colour array outside the controller: cleared by seg_clear, shifts in at entry 0.
  always @(posedge clk) begin
    if (reset || seg_clear) segment <= '0;
    else if (load_colour) segment <= {segment[63:0], new_colour};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {15'd0, seg_clear, load_colour, new_colour, led_en, led_colour,
            awaiting_input, round_len, busy, win, fail};
  endfunction

  task automatic press(input logic [1:0] c);
    btn_colour = c;
    btn_valid  = 1'b1;
    step();
    btn_valid  = 1'b0;
  endtask

  task automatic begin_game(input logic [1:0] c);
    colours.delete();
    colours.push_back(c);
    rand_colour = c;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_seg", seg_clear, 1);
    chk("clear_busy", busy, 1);
    step();
    chk("clear_one_cycle", seg_clear, 0);
    chk("add_load", load_colour, 1);
    chk("add_new_colour", new_colour, c);
    step();
    chk("round_len_first", round_len, 1);
    chk("load_one_cycle", load_colour, 0);
  endtask

  task automatic next_round(input logic [1:0] press_c, input logic [1:0] rand_c);
    colours.push_back(rand_c);
    rand_colour = rand_c;
    press(press_c);
    chk("next_load", load_colour, 1);
    chk("next_no_fail", fail, 0);
    chk("next_new_colour", new_colour, rand_c);
    step();
    chk("next_round_len", round_len, colours.size());
  endtask

  // Pops each stored colour as it is lit and checks its on and off lengths.
  task automatic playback(input bit inject);
    logic [1:0] exp_q[$];
    logic [1:0] c, seen;
    int unsigned guard, on_n, off_n;
    bit inj;
    inj = inject;
    exp_q = colours;
    guard = 0;
    while (!led_en && guard < 20) begin step(); guard++; end
    chk("play_start", led_en, 1);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      seen = c;
      on_n = 0;
      while (led_en && on_n < 50) begin
        if (led_colour !== c && seen === c) seen = led_colour;
        if (inj) begin
          start = 1'b1;
          btn_valid = 1'b1;
          btn_colour = ~c;
          inj = 1'b0;
        end
        on_n++;
        step();
        start = 1'b0;
        btn_valid = 1'b0;
      end
      chk("led_colour", seen, c);
      chk("on_cycles", on_n, ON);
      off_n = 0;
      while (!led_en && !awaiting_input && off_n < 50) begin off_n++; step(); end
      chk("off_cycles", off_n, OFF);
    end
    chk("await_after_play", awaiting_input, 1);
    chk("round_len_play", round_len, colours.size());
  endtask

  initial begin
    int unsigned n;
    step();
    step();
    reset = 1'b0;
    chk("reset_outputs", all_outs(), 0);
    press(2'd1);
    chk("idle_press_busy", busy, 0);
    chk("idle_press_await", awaiting_input, 0);

    // Full winning game: 2, 1, 3
    begin_game(2'd2);
    playback(1'b0);
    next_round(2'd2, 2'd1);
    playback(1'b0);
    press(2'd2);
    chk("mid_press_await", awaiting_input, 1);
    next_round(2'd1, 2'd3);
    playback(1'b0);
    press(2'd2);
    press(2'd1);
    press(2'd3);
    chk("win_pulse", win, 1);
    chk("win_no_fail", fail, 0);
    step();
    chk("win_one_cycle", win, 0);
    chk("win_idle_busy", busy, 0);
    chk("win_round_len", round_len, 3);

    // Wrong first press in round 2, start during FAIL ignored
    begin_game(2'd2);
    playback(1'b0);
    next_round(2'd2, 2'd1);
    playback(1'b0);
    press(2'd3);
    chk("fail_pulse", fail, 1);
    chk("fail_await", awaiting_input, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fail_one_cycle", fail, 0);
    chk("fail_idle_busy", busy, 0);
    chk("fail_round_len", round_len, 2);
    step();
    chk("start_in_fail_ignored", busy, 0);
    press(2'd2);
    chk("press_after_fail_busy", busy, 0);
    chk("press_after_fail_fail", fail, 0);

    // Restart; press on cycle 20 is input, then timer reload and timeout
    begin_game(2'd1);
    playback(1'b0);
    repeat (TO - 1) step();
    chk("wait_cycle20_await", awaiting_input, 1);
    next_round(2'd1, 2'd0);
    playback(1'b0);
    repeat (9) step();
    press(2'd1);
    chk("reload_press_await", awaiting_input, 1);
    n = 0;
    while (awaiting_input && n < 40) begin n++; step(); end
    chk("timeout_cycles", n, TO);
    chk("timeout_fail", fail, 1);
    step();
    chk("timeout_idle", busy, 0);

    // Ignored start/press during playback, then reset mid SHOW_ON
    begin_game(2'd3);
    playback(1'b1);
    next_round(2'd3, 2'd2);
    step();
    step();
    chk("pre_reset_led", led_en, 1);
    reset = 1'b1;
    step();
    chk("mid_reset_outputs", all_outs(), 0);
    reset = 1'b0;
    step();
    chk("post_reset_outputs", all_outs(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
